// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// baud-tick divider calculation used by both UART halves.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   // Integer floor of clk_hz / (baud * os); one tick per oversample slot.
   function automatic int baud_div(input int clk_hz, input int baud, input int os);
      return clk_hz / (baud * os);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bus between the serial line / UART register block and uart_rx.
interface uart_rx_if;
   import uart_pkg::*;

   logic                      rxd;
   logic                      rx_ack;
   logic                      err_clr;
   logic [UART_DATA_BITS-1:0] rx_data;
   logic                      rx_valid;
   logic                      frame_err;
   logic                      overrun;
   logic                      busy;

   modport master (
      output rxd, rx_ack, err_clr,
      input  rx_data, rx_valid, frame_err, overrun, busy
   );

   modport slave (
      input  rxd, rx_ack, err_clr,
      output rx_data, rx_valid, frame_err, overrun, busy
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clk pulse every DIV clocks.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int DIV = 325
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, OVERSAMPLE x oversampled, with a one-byte holding
// register and sticky framing/overrun flags. OVERSAMPLE must be even and >= 8.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input logic     clk,
   input logic     rst,
   uart_rx_if.slave bus
);

   localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int SCW = $clog2(OVERSAMPLE);
   localparam logic [SCW-1:0] SC_HALF = SCW'(OVERSAMPLE / 2 - 1);
   localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

   logic                      tick;
   logic                      rxd_p0;
   logic                      rxd_s;
   rx_state_t                 state;
   logic [SCW-1:0]            sc;
   logic [2:0]                bit_idx;
   logic [UART_DATA_BITS-1:0] shreg;
   logic                      busy;
   logic                      done_p1;
   logic                      fe_set_p1;
   logic [UART_DATA_BITS-1:0] rx_data;
   logic                      rx_valid;
   logic                      frame_err;
   logic                      overrun;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Stage p0/s: two-flop synchronizer, reset to the idle line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_p0 <= 1'b1;
         rxd_s  <= 1'b1;
      end else begin
         rxd_p0 <= bus.rxd;
         rxd_s  <= rxd_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sc        <= '0;
         bit_idx   <= '0;
         busy      <= 1'b0;
         done_p1   <= 1'b0;
         fe_set_p1 <= 1'b0;
      end else begin
         done_p1   <= 1'b0;
         fe_set_p1 <= 1'b0;
         if (tick) begin
            unique case (state)
               IDLE: if (!rxd_s) begin
                  state <= START;
                  sc    <= '0;
                  busy  <= 1'b1;
               end
               START: if (sc == SC_HALF) begin
                  sc      <= '0;
                  bit_idx <= '0;
                  if (!rxd_s) begin
                     state <= DATA;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  sc <= sc + 1'b1;
               end
               DATA: if (sc == SC_LAST) begin
                  shreg   <= {rxd_s, shreg[UART_DATA_BITS-1:1]};
                  sc      <= '0;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  sc <= sc + 1'b1;
               end
               STOP: if (sc == SC_LAST) begin
                  sc <= '0;
                  if (rxd_s) begin
                     state   <= IDLE;
                     busy    <= 1'b0;
                     done_p1 <= 1'b1;
                  end else begin
                     // A low stop bit may be a break; wait for the line to idle.
                     state     <= WAIT_IDLE;
                     fe_set_p1 <= 1'b1;
                  end
               end else begin
                  sc <= sc + 1'b1;
               end
               WAIT_IDLE: if (rxd_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Stage p1 -> holding register: completion in the ack cycle replaces the byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (done_p1 && (!rx_valid || bus.rx_ack)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (bus.rx_ack) begin
            rx_valid <= 1'b0;
         end
         overrun   <= (done_p1 && rx_valid && !bus.rx_ack) || (overrun && !bus.err_clr);
         frame_err <= fe_set_p1 || (frame_err && !bus.err_clr);
      end
   end

   assign bus.rx_data   = rx_data;
   assign bus.rx_valid  = rx_valid;
   assign bus.frame_err = frame_err;
   assign bus.overrun   = overrun;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV = 2 (one bit = 32 clk).
module tb_uart_rx;

   localparam int BIT_CLK = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   uart_rx_if bus();

   uart_rx #(
      .CLK_HZ     (3200000),
      .BAUD       (100000),
      .OVERSAMPLE (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      bus.rxd = v;
      clk_wait(BIT_CLK);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      if (bad_stop) begin
         drive_bit(1'b0);
         drive_bit(1'b0);
      end
      drive_bit(1'b1);
   endtask

   task automatic pulse_ack_clr(input logic ack, input logic clr);
      bus.rx_ack  = ack;
      bus.err_clr = clr;
      clk_wait(1);
      bus.rx_ack  = 1'b0;
      bus.err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clk_wait(4);
      @(negedge clk);
      tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", bus.rx_data); end
      tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.rx_valid); end
      tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr got %b want 0", bus.frame_err); end
      tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr got %b want 0", bus.overrun); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      @(posedge clk); #1;
      rst = 1'b0;
      clk_wait(10);
   endtask

   task automatic test_basic();
      int n;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(1'((8'h55 >> i) & 1));
      bus.rxd = 1'b1;
      clk_wait(BIT_CLK / 2);
      n = 0;
      @(negedge clk);
      while (!bus.rx_valid && n < 33) begin @(negedge clk); n++; end
      tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_latency got %b want 1 within 33 clk", bus.rx_valid); end
      tests++; if (bus.rx_data !== 8'h55) begin fails++; $display("FAIL basic_data got %h want 55", bus.rx_data); end
      tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL basic_ferr got %b want 0", bus.frame_err); end
      @(posedge clk); #1;
      clk_wait(BIT_CLK);
      pulse_ack_clr(1'b1, 1'b0);
      @(negedge clk);
      tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL basic_ack_valid got %b want 0", bus.rx_valid); end
      tests++; if (bus.rx_data !== 8'h55) begin fails++; $display("FAIL basic_ack_data got %h want 55", bus.rx_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_glitch();
      bit saw_busy;
      saw_busy = 1'b0;
      bus.rxd = 1'b0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); saw_busy |= bus.busy; end
      @(posedge clk); #1;
      bus.rxd = 1'b1;
      for (int i = 0; i < 40; i++) begin @(negedge clk); saw_busy |= bus.busy; end
      tests++; if (saw_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_seen got %b want 1", saw_busy); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end got %b want 0", bus.busy); end
      tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL glitch_valid got %b want 0", bus.rx_valid); end
      tests++; if ({bus.frame_err, bus.overrun} !== 2'b00) begin fails++; $display("FAIL glitch_flags got %b want 00", {bus.frame_err, bus.overrun}); end
      @(posedge clk); #1;
   endtask

   task automatic test_frame_err();
      send_byte(8'hA3, 1'b1);
      @(negedge clk);
      tests++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL ferr_set got %b want 1", bus.frame_err); end
      tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL ferr_valid got %b want 0", bus.rx_valid); end
      @(posedge clk); #1;
      send_byte(8'h3C, 1'b0);
      @(negedge clk);
      tests++; if (bus.rx_data !== 8'h3C) begin fails++; $display("FAIL ferr_next_data got %h want 3c", bus.rx_data); end
      tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL ferr_next_valid got %b want 1", bus.rx_valid); end
      tests++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL ferr_sticky got %b want 1", bus.frame_err); end
      @(posedge clk); #1;
      pulse_ack_clr(1'b1, 1'b1);
      @(negedge clk);
      tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL ferr_clear got %b want 0", bus.frame_err); end
      tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL ferr_ack got %b want 0", bus.rx_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      @(negedge clk);
      tests++; if (bus.rx_data !== 8'h12) begin fails++; $display("FAIL b2b_data got %h want 12", bus.rx_data); end
      tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL b2b_overrun got %b want 1", bus.overrun); end
      tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got %b want 1", bus.rx_valid); end
      @(posedge clk); #1;
      pulse_ack_clr(1'b1, 1'b1);
      @(negedge clk);
      tests++; if ({bus.overrun, bus.rx_valid} !== 2'b00) begin fails++; $display("FAIL b2b_clear got %b want 00", {bus.overrun, bus.rx_valid}); end
      @(posedge clk); #1;
   endtask

   task automatic test_ack_on_complete();
      bit hit;
      hit = 1'b0;
      send_byte(8'h12, 1'b0);
      fork
         send_byte(8'h34, 1'b0);
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.busy && n < 400) begin @(negedge clk); n++; end
            n = 0;
            while (bus.busy && n < 400) begin @(negedge clk); n++; end
            if (!bus.busy) begin
               hit = 1'b1;
               bus.rx_ack = 1'b1;
               @(posedge clk); #1;
               bus.rx_ack = 1'b0;
            end
         end
      join
      @(negedge clk);
      tests++; if (hit !== 1'b1) begin fails++; $display("FAIL ackc_completion_seen got %b want 1", hit); end
      tests++; if (bus.rx_data !== 8'h34) begin fails++; $display("FAIL ackc_data got %h want 34", bus.rx_data); end
      tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL ackc_valid got %b want 1", bus.rx_valid); end
      tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL ackc_overrun got %b want 0", bus.overrun); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_frame();
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      bus.rxd = 1'b1;
      clk_wait(BIT_CLK / 2);
      rst = 1'b1;
      clk_wait(2);
      rst = 1'b0;
      clk_wait(6 * BIT_CLK);
      @(negedge clk);
      tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", bus.rx_valid); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
      @(posedge clk); #1;
      send_byte(8'h00, 1'b0);
      @(negedge clk);
      tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL rstmid_data got %h want 00", bus.rx_data); end
      tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL rstmid_next_valid got %b want 1", bus.rx_valid); end
      tests++; if ({bus.frame_err, bus.overrun} !== 2'b00) begin fails++; $display("FAIL rstmid_flags got %b want 00", {bus.frame_err, bus.overrun}); end
      @(posedge clk); #1;
   endtask

   initial begin
      bus.rxd     = 1'b1;
      bus.rx_ack  = 1'b0;
      bus.err_clr = 1'b0;
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_ack_on_complete();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
